uart_prog_loader: RTL and testbench

Boot-time program writer for the RISC-V processor's instruction memory.
- Receives a framed program image over a UART RX line and writes 32-bit words into instruction memory through a single write port.
- Holds the processor in reset until the image has loaded, then releases it.
- Sits in soc between the board RX pin and the CPU's MEM write port, replacing initial-block preloading on hardware.

---
 rtl/uart_prog_loader_pkg.sv | 28 ++
 rtl/uart_prog_loader_if.sv | 16 +
 rtl/uart_prog_loader_uart_rx.sv | 116 +++++++++++
 rtl/uart_prog_loader.sv | 179 +++++++++++++++++
 tb/tb_uart_prog_loader.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_prog_loader_pkg.sv
// uart_prog_loader_pkg
//   Shared constants for the UART program loader: frame layout and the
//   state encodings of the loader FSM and of the UART receiver.
//   Optional build macro: PROG_LOADER_CHECKSUM_EN adds the CHECK state.
package uart_prog_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int COUNT_BYTES    = 2;
  localparam int WORD_W         = BYTES_PER_WORD * 8;
  localparam int COUNT_W        = COUNT_BYTES * 8;
  localparam int BIDX_W         = $clog2(BYTES_PER_WORD);
  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES_PER_WORD - 1);

  localparam logic [2:0] ST_CNT_LO = 3'd0;
  localparam logic [2:0] ST_CNT_HI = 3'd1;
  localparam logic [2:0] ST_WORD   = 3'd2;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CHECK  = 3'd3;
`endif
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_ERROR  = 3'd5;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

endpackage

// File: rtl/uart_prog_loader_if.sv
// uart_prog_loader_if
//   Instruction-memory write port driven by the loader.
//   mem_we    : one-cycle write strobe
//   mem_addr  : word address (ADDR_WIDTH bits)
//   mem_wdata : 32-bit word
//   master = loader side, slave = memory side.
interface uart_prog_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (output mem_we, mem_addr, mem_wdata);
  modport slave  (input  mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/uart_prog_loader_uart_rx.sv
// uart_rx
//   8N1 UART receiver, LSB first, idle high. Reusable for a console UART.
//   CLK        : system clock
//   reset      : synchronous, active-high
//   RXD        : asynchronous serial input (2-flop synchronised here)
//   byte_valid : one-cycle pulse, byte_data valid with it
//   byte_data  : received byte
//   frame_err  : one-cycle pulse when the stop bit samples low
//
// state    | meaning
// RX_IDLE  | waiting for a falling edge on the synchronised line
// RX_START | counting to mid start bit; high there means glitch
// RX_DATA  | sampling 8 data bits at mid-bit
// RX_STOP  | sampling the stop bit at mid-bit
module uart_rx
  import uart_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       RXD,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

  logic          sync1_q, sync2_q, prev_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d, ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          cnt_d   = HALF_CNT;
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          if (sync2_q) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
            cnt_d   = FULL_CNT;
            bit_d   = 3'd0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          cnt_d   = FULL_CNT;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        if (cnt_q == '0) begin
          valid_d = sync2_q;
          ferr_d  = !sync2_q;
          state_d = RX_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= RXD;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_prog_loader.sv
// uart_prog_loader
//   Boot-time writer of the CPU instruction memory from a UART image.
//   Frame: cnt_lo, cnt_hi, then N little-endian 32-bit words.
//   Optional macro PROG_LOADER_CHECKSUM_EN: one trailing XOR byte over all
//   preceding frame bytes, verified in a CHECK state.
//   CLK, reset : clock and synchronous active-high reset
//   RXD        : UART receive line
//   mem        : instruction-memory write port (master)
//   cpu_reset  : holds the CPU in reset until the image has loaded
//   busy       : frame in progress
//   done       : sticky, image loaded
//   error      : sticky, framing/length/check fault
//
// state     | meaning
// ST_CNT_LO | waiting for count low byte
// ST_CNT_HI | waiting for count high byte, length check
// ST_WORD   | assembling words and issuing writes
// ST_CHECK  | waiting for checksum byte (checksum build only)
// ST_DONE   | image loaded, CPU released, RX ignored
// ST_ERROR  | fault, CPU held, until reset
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                RXD,
  uart_prog_loader_if.master  mem,
  output logic                cpu_reset,
  output logic                busy,
  output logic                done,
  output logic                error
);

  logic             rx_valid, rx_err;
  logic [7:0]       rx_data;

  logic [2:0]              state_q, state_d;
  logic [7:0]              cnt_lo_q, cnt_lo_d;
  logic [ADDR_WIDTH:0]     n_q, n_d, idx_q, idx_d;
  logic [BIDX_W-1:0]       bidx_q, bidx_d;
  logic [WORD_W-1:0]       word_q, word_d, wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [COUNT_W-1:0]      n_full;
  logic [2:0]              st_after_words;
  logic                    csum_ok;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .CLK        (CLK),
    .reset      (reset),
    .RXD        (RXD),
    .byte_valid (rx_valid),
    .byte_data  (rx_data),
    .frame_err  (rx_err)
  );

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (rx_valid && (state_q == ST_CNT_LO || state_q == ST_CNT_HI || state_q == ST_WORD))
      csum_d = csum_q ^ rx_data;
  end

  always_ff @(posedge CLK) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end

  assign st_after_words = ST_CHECK;
  assign csum_ok        = (rx_data == csum_q);
`else
  assign st_after_words = ST_DONE;
  assign csum_ok        = 1'b0;
`endif

  assign n_full = {rx_data, cnt_lo_q};

  always_comb begin
    state_d  = state_q;
    cnt_lo_d = cnt_lo_q;
    n_d      = n_q;
    idx_d    = idx_q;
    bidx_d   = bidx_q;
    word_d   = word_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    if (rx_err && state_q != ST_DONE) begin
      state_d = ST_ERROR;
    end else begin
      case (state_q)
        ST_CNT_LO: begin
          if (rx_valid) begin
            cnt_lo_d = rx_data;
            state_d  = ST_CNT_HI;
          end
        end
        ST_CNT_HI: begin
          if (rx_valid) begin
            // widened compare so that ADDR_WIDTH up to 16 still works
            if ({16'b0, n_full} > (32'd1 << ADDR_WIDTH)) begin
              state_d = ST_ERROR;
            end else begin
              n_d     = (ADDR_WIDTH + 1)'(n_full);
              idx_d   = '0;
              bidx_d  = '0;
              state_d = (n_full == '0) ? st_after_words : ST_WORD;
            end
          end
        end
        ST_WORD: begin
          if (rx_valid) begin
            word_d = {rx_data, word_q[WORD_W-1:8]};
            bidx_d = bidx_q + 1'b1;
            if (bidx_q == LAST_BYTE) begin
              we_d    = 1'b1;
              addr_d  = idx_q[ADDR_WIDTH-1:0];
              wdata_d = {rx_data, word_q[WORD_W-1:8]};
            end
          end
          // index advances in the write cycle so done follows the last strobe
          if (we_q) begin
            idx_d = idx_q + 1'b1;
            if ((idx_q + 1'b1) == n_q) state_d = st_after_words;
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (rx_valid) state_d = csum_ok ? ST_DONE : ST_ERROR;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= ST_CNT_LO;
      cnt_lo_q <= '0;
      n_q      <= '0;
      idx_q    <= '0;
      bidx_q   <= '0;
      word_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_lo_q <= cnt_lo_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      bidx_q   <= bidx_d;
      word_q   <= word_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

`ifdef PROG_LOADER_CHECKSUM_EN
  assign busy = (state_q == ST_WORD) || (state_q == ST_CHECK);
`else
  assign busy = (state_q == ST_WORD);
`endif
  assign done      = (state_q == ST_DONE);
  assign error     = (state_q == ST_ERROR);
  assign cpu_reset = (state_q != ST_DONE) || csum_ok & 1'b0;

endmodule

// File: tb/tb_uart_prog_loader.sv
module tb_uart_prog_loader;

  localparam int CPB = 8;
  localparam int AW  = 4;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit LAST_DONE = 1'b0;
`else
  localparam bit LAST_DONE = 1'b1;
`endif

  logic CLK = 1'b0;
  logic reset = 1'b1;
  logic RXD = 1'b1;
  logic cpu_reset, busy, done, error;

  uart_prog_loader_if #(.ADDR_WIDTH(AW)) mem_if ();

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .RXD       (RXD),
    .mem       (mem_if.master),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    bit            last;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         we_cnt = 0;
  bit         done_pending = 1'b0;
  logic [7:0] csum;

  // scoreboard monitor: every write strobe pops an expectation
  always @(negedge CLK) begin
    exp_t e;
    if (reset) begin
      done_pending = 1'b0;
    end else begin
      if (done_pending) begin
        checks++;
        if (!(done === 1'b1 && cpu_reset === 1'b0)) begin
          errors++;
          $display("FAIL done_after_last_we: done=%0b cpu_reset=%0b, want done=1 cpu_reset=0",
                   done, cpu_reset);
        end
        done_pending = 1'b0;
      end
      if (mem_if.mem_we === 1'b1) begin
        we_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_we: addr=%0h data=%08h, want no write",
                   mem_if.mem_addr, mem_if.mem_wdata);
        end else begin
          e = exp_q.pop_front();
          if (mem_if.mem_addr !== e.addr || mem_if.mem_wdata !== e.data) begin
            errors++;
            $display("FAIL mem_write: addr=%0h data=%08h, want addr=%0h data=%08h",
                     mem_if.mem_addr, mem_if.mem_wdata, e.addr, e.data);
          end
          if (e.last) done_pending = 1'b1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    RXD   = 1'b1;
    tick(n);
    reset = 1'b0;
    exp_q.delete();
    tick(2);
  endtask

  task automatic send_raw(input logic [7:0] b, input logic stop_val);
    csum = csum ^ b;
    RXD = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      tick(CPB);
    end
    RXD = stop_val;
    tick(CPB);
    RXD = 1'b1;
    tick(3);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_raw(b, 1'b1);
  endtask

  task automatic send_count(input logic [15:0] n);
    csum = 8'h00;
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic send_csum();
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] c;
    c = csum;
    send_byte(c);
`endif
  endtask

  task automatic expect_we(input logic [AW-1:0] a, input logic [31:0] d, input bit last);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic check_status(input string tag, input logic exp_done, input logic exp_err,
                              input logic exp_cpu_rst);
    check({tag, "_done"}, {31'b0, done}, {31'b0, exp_done});
    check({tag, "_error"}, {31'b0, error}, {31'b0, exp_err});
    check({tag, "_cpu_reset"}, {31'b0, cpu_reset}, {31'b0, exp_cpu_rst});
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  int w0;

  initial begin
    tick(3);
    reset = 1'b0;
    #0;
    check("rst_mem_we", {31'b0, mem_if.mem_we}, 32'd0);
    check("rst_mem_addr", {28'b0, mem_if.mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_if.mem_wdata, 32'd0);
    check_status("rst", 1'b0, 1'b0, 1'b1);
    tick(2);

    // three identical words
    w0 = we_cnt;
    send_count(16'h0003);
    check("s1_busy", {31'b0, busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      expect_we(AW'(i), 32'h00208033, (i == 2) && LAST_DONE);
      send_word(32'h00208033);
    end
    send_csum();
    tick(10);
    check("s1_we_count", we_cnt - w0, 32'd3);
    check("s1_queue_empty", exp_q.size(), 32'd0);
    check_status("s1", 1'b1, 1'b0, 1'b0);

    // empty image
    apply_reset(2);
    w0 = we_cnt;
    send_count(16'h0000);
    send_csum();
    tick(5);
    check("s2_we_count", we_cnt - w0, 32'd0);
    check_status("s2", 1'b1, 1'b0, 1'b0);

    // count too large, later bytes ignored
    apply_reset(2);
    w0 = we_cnt;
    send_count(16'h0011);
    tick(3);
    check_status("s3", 1'b0, 1'b1, 1'b1);
    send_word(32'h00208033);
    tick(5);
    check("s3_we_count", we_cnt - w0, 32'd0);
    check("s3_error_hold", {31'b0, error}, 32'd1);

    // framing error mid-word
    apply_reset(2);
    w0 = we_cnt;
    send_count(16'h0001);
    send_byte(8'h12);
    send_byte(8'h34);
    send_raw(8'h56, 1'b0);
    tick(5);
    check("s4_we_count", we_cnt - w0, 32'd0);
    check_status("s4", 1'b0, 1'b1, 1'b1);

    // reset mid-frame, then a complete frame
    apply_reset(2);
    w0 = we_cnt;
    send_count(16'h0002);
    expect_we(AW'(0), 32'h11223344, 1'b0);
    send_word(32'h11223344);
    tick(2);
    check("s5_first_word", we_cnt - w0, 32'd1);
    apply_reset(1);
    check_status("s5_rst", 1'b0, 1'b0, 1'b1);
    w0 = we_cnt;
    send_count(16'h0001);
    expect_we(AW'(0), 32'hDEADBEEF, LAST_DONE);
    send_word(32'hDEADBEEF);
`ifdef PROG_LOADER_CHECKSUM_EN
    check("s5_csum_model", {24'b0, csum}, 32'h23);
`endif
    send_csum();
    tick(10);
    check("s5_we_count", we_cnt - w0, 32'd1);
    check_status("s5", 1'b1, 1'b0, 1'b0);

    // start-bit glitch: no byte consumed, FSM still at count low
    apply_reset(2);
    w0 = we_cnt;
    RXD = 1'b0;
    tick(2);
    RXD = 1'b1;
    tick(4 * CPB);
    check("s6_glitch_error", {31'b0, error}, 32'd0);
    check("s6_glitch_done", {31'b0, done}, 32'd0);
    send_count(16'h0000);
    send_csum();
    tick(5);
    check("s6_we_count", we_cnt - w0, 32'd0);
    check_status("s6", 1'b1, 1'b0, 1'b0);

    // full-capacity image, no index wrap
    apply_reset(2);
    w0 = we_cnt;
    send_count(16'h0010);
    for (int i = 0; i < 16; i++) begin
      expect_we(AW'(i), 32'hA5C30000 | 32'(i), (i == 15) && LAST_DONE);
      send_word(32'hA5C30000 | 32'(i));
    end
    send_csum();
    tick(10);
    check("s7_we_count", we_cnt - w0, 32'd16);
    check_status("s7", 1'b1, 1'b0, 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
    // bad checksum
    apply_reset(2);
    send_count(16'h0001);
    expect_we(AW'(0), 32'hDEADBEEF, 1'b0);
    send_word(32'hDEADBEEF);
    send_byte(8'h24);
    tick(5);
    check_status("s8", 1'b0, 1'b1, 1'b1);
`endif

    tick(5);
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
